// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
// ============================================================================
// Module   : mem_arb_starve_ctr
// Brief    : Counts consecutive fetch losses to the data port and flags when
//            the fetch port must be forced to win.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lost,
  output logic o_force_i
);

  localparam logic [3:0] C_MAX = 4'(STARVE_MAX);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_lost) begin
      if (r_cnt != C_MAX) r_cnt <= r_cnt + 4'd1;
    end else begin
      r_cnt <= 4'd0;
    end
  end

  assign o_force_i = (r_cnt == C_MAX);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port memory between a fetch port and a data
//            port, and sequences the memory dump handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              dump_req,
  output logic              dump_done,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_createdump
);

  arb_state_t        r_state;
  logic              r_i_rvalid, r_d_rvalid;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;
  logic              r_createdump, r_dump_done;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [DATA_W-1:0] r_wdata_hold;

  logic w_run, w_force_i, w_i_win, w_d_win, w_winner;

  // A dump request in RUN already blocks grants so the drain starts clean.
  assign w_run    = rst_n && (r_state == RUN) && !dump_req;
  assign w_i_win  = w_run && i_req && (!d_req || w_force_i);
  assign w_d_win  = w_run && d_req && !w_i_win;
  assign w_winner = w_d_win ? PORT_D : PORT_I;

  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_lost    (i_req && w_d_win),
    .o_force_i (w_force_i)
  );

  assign i_gnt      = w_i_win;
  assign d_gnt      = w_d_win;
  assign mem_enable = w_i_win || w_d_win;
  assign mem_wr     = w_d_win && d_wr;
  assign mem_addr   = !mem_enable ? r_addr_hold :
                      (w_winner == PORT_D) ? d_addr : i_addr;
  assign mem_wdata  = w_d_win ? d_wdata : r_wdata_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_i_rvalid   <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_createdump <= 1'b0;
      r_dump_done  <= 1'b0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_createdump <= 1'b0;
      r_dump_done  <= 1'b0;
      case (r_state)
        RUN:   if (dump_req) r_state <= DRAIN;
        DRAIN: begin
          r_state      <= DUMP;
          r_createdump <= 1'b1;
        end
        DUMP:  begin
          r_state     <= DONE;
          r_dump_done <= 1'b1;
        end
        DONE:  if (!dump_req) r_state <= RUN;
        default: r_state <= RUN;
      endcase

      r_i_rvalid <= w_i_win;
      r_d_rvalid <= w_d_win && !d_wr;
      if (w_i_win)           r_i_rdata <= mem_rdata;
      if (w_d_win && !d_wr)  r_d_rdata <= mem_rdata;
      if (mem_enable)        r_addr_hold  <= mem_addr;
      if (w_d_win)           r_wdata_hold <= d_wdata;
    end
  end

  assign i_rvalid       = r_i_rvalid;
  assign i_rdata        = r_i_rdata;
  assign d_rvalid       = r_d_rvalid;
  assign d_rdata        = r_d_rdata;
  assign mem_createdump = r_createdump;
  assign dump_done      = r_dump_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench with an attached memory and a reference
//            model of memory contents and grant fairness.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr, dump_req;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, dump_done;
  logic [15:0] i_rdata, d_rdata;
  logic        mem_enable, mem_wr, mem_createdump;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr, pl_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .dump_req(dump_req), .dump_done(dump_done),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_createdump(mem_createdump)
  );

  // Behavioural single-port memory: combinational read, write at the edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_enable && mem_wr) mem[mem_addr] <= mem_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    ref_mem[a] = v;
    step();
    pl_en = 1'b0;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; dump_req = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    step();
    preload(16'h0010, 16'hBEEF);
    for (int a = 0; a < 16; a++) preload(16'(a), 16'($urandom));
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt: i_gnt=%b d_gnt=%b mem_enable=%b required 0 0 0", i_gnt, d_gnt, mem_enable);
    end
    step();
    checks++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || dump_done !== 1'b0 || mem_createdump !== 1'b0 ||
        i_rdata !== 16'h0 || d_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_outs: irv=%b drv=%b done=%b cd=%b irdata=%h drdata=%h required all 0",
               i_rvalid, d_rvalid, dump_done, mem_createdump, i_rdata, d_rdata);
    end
    idle_inputs();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_enable !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL fetch_gnt: i_gnt=%b d_gnt=%b en=%b wr=%b addr=%h required 1 0 1 0 0010",
               i_gnt, d_gnt, mem_enable, mem_wr, mem_addr);
    end
    step();
    i_req = 1'b0;
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 16'hBEEF || d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_data: irv=%b irdata=%h drv=%b required 1 beef 0", i_rvalid, i_rdata, d_rvalid);
    end
    step();
    checks++;
    if (i_rvalid !== 1'b0 || i_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL fetch_hold: irv=%b irdata=%h required 0 beef", i_rvalid, i_rdata);
    end
  endtask

  task automatic test_write_read();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0200 || mem_wdata !== 16'h1234) begin
      errors++;
      $display("FAIL wr_gnt: d_gnt=%b wr=%b addr=%h wdata=%h required 1 1 0200 1234",
               d_gnt, mem_wr, mem_addr, mem_wdata);
    end
    ref_mem[16'h0200] = 16'h1234;
    step();
    d_wr = 1'b0;
    checks++;
    if (d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_no_rvalid: d_rvalid=%b required 0", d_rvalid);
    end
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_wr !== 1'b0 || mem_enable !== 1'b1) begin
      errors++;
      $display("FAIL rd_gnt: d_gnt=%b wr=%b en=%b required 1 0 1", d_gnt, mem_wr, mem_enable);
    end
    step();
    d_req = 1'b0;
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 16'h1234 || i_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL raw_data: drv=%b drdata=%h irv=%b required 1 1234 0", d_rvalid, d_rdata, i_rvalid);
    end
    step();
  endtask

  task automatic test_starve();
    int passed_over = 0;
    int gap = 0;
    int max_gap = 0;
    logic exp_i, exp_d;
    idle_inputs();
    step();
    i_req = 1'b1; i_addr = 16'h0003;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0005;
    for (int c = 0; c < 20; c++) begin
      // The fetch port wins only after being passed over STARVE_MAX times running.
      exp_i = (passed_over == STARVE_MAX);
      exp_d = !exp_i;
      @(negedge clk);
      checks++;
      if (i_gnt !== exp_i || d_gnt !== exp_d) begin
        errors++;
        $display("FAIL starve_gnt[%0d]: i_gnt=%b d_gnt=%b required %b %b", c, i_gnt, d_gnt, exp_i, exp_d);
      end
      passed_over = exp_i ? 0 : ((passed_over < STARVE_MAX) ? passed_over + 1 : STARVE_MAX);
      gap = i_gnt ? 0 : gap + 1;
      if (gap > max_gap) max_gap = gap;
      step();
      checks++;
      if (exp_i ? (i_rvalid !== 1'b1 || i_rdata !== ref_mem[16'h0003])
                : (d_rvalid !== 1'b1 || d_rdata !== ref_mem[16'h0005])) begin
        errors++;
        $display("FAIL starve_data[%0d]: irv=%b irdata=%h drv=%b drdata=%h", c, i_rvalid, i_rdata, d_rvalid, d_rdata);
      end
    end
    checks++;
    if (max_gap > STARVE_MAX) begin
      errors++;
      $display("FAIL starve_gap: max fetch gap=%0d required <= %0d", max_gap, STARVE_MAX);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    int passed_over = 0;
    logic ip = 1'b0, dp = 1'b0, dw = 1'b0;
    logic [15:0] ia = '0, da = '0, dwd = '0;
    logic exp_i, exp_d;
    logic [15:0] exp_data;
    for (int c = 0; c < 300; c++) begin
      if (!ip && ($urandom % 2 == 0)) begin ip = 1'b1; ia = 16'($urandom % 16); end
      if (!dp && ($urandom % 2 == 0)) begin
        dp = 1'b1; dw = 1'($urandom % 2); da = 16'($urandom % 16); dwd = 16'($urandom);
      end
      i_req = ip; i_addr = ia; d_req = dp; d_wr = dw; d_addr = da; d_wdata = dwd;
      exp_i = ip && (!dp || passed_over == STARVE_MAX);
      exp_d = dp && !exp_i;
      exp_data = exp_i ? ref_mem[ia] : ref_mem[da];
      @(negedge clk);
      checks++;
      if (i_gnt !== exp_i || d_gnt !== exp_d) begin
        errors++;
        $display("FAIL rnd_gnt[%0d]: i_gnt=%b d_gnt=%b required %b %b", c, i_gnt, d_gnt, exp_i, exp_d);
      end
      if (exp_i || exp_d) begin
        checks++;
        if (mem_addr !== (exp_i ? ia : da) || mem_wr !== (exp_d && dw)) begin
          errors++;
          $display("FAIL rnd_access[%0d]: addr=%h wr=%b required %h %b", c, mem_addr, mem_wr,
                   exp_i ? ia : da, exp_d && dw);
        end
      end
      passed_over = (ip && exp_d) ? ((passed_over < STARVE_MAX) ? passed_over + 1 : STARVE_MAX) : 0;
      if (exp_d && dw) ref_mem[da] = dwd;
      step();
      checks++;
      if (i_rvalid !== exp_i || d_rvalid !== (exp_d && !dw) ||
          (exp_i && i_rdata !== exp_data) || (exp_d && !dw && d_rdata !== exp_data)) begin
        errors++;
        $display("FAIL rnd_resp[%0d]: irv=%b irdata=%h drv=%b drdata=%h required irv=%b drv=%b data=%h",
                 c, i_rvalid, i_rdata, d_rvalid, d_rdata, exp_i, exp_d && !dw, exp_data);
      end
      if (exp_i) ip = 1'b0;
      if (exp_d) dp = 1'b0;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_dump();
    int n_cd = 0;
    int n_done = 0;
    bit resumed = 1'b0;
    i_req = 1'b1; i_addr = 16'h0001;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0002;
    dump_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_enable !== 1'b0 ||
          mem_createdump !== (k == 2) || dump_done !== (k == 3)) begin
        errors++;
        $display("FAIL dump_seq[%0d]: i_gnt=%b d_gnt=%b en=%b cd=%b done=%b required 0 0 0 %b %b",
                 k, i_gnt, d_gnt, mem_enable, mem_createdump, dump_done, k == 2, k == 3);
      end
      if (mem_createdump === 1'b1) n_cd++;
      if (dump_done === 1'b1) n_done++;
      step();
    end
    checks++;
    if (n_cd != 1 || n_done != 1) begin
      errors++;
      $display("FAIL dump_once: createdump cycles=%0d dump_done cycles=%0d required 1 1", n_cd, n_done);
    end
    dump_req = 1'b0;
    for (int k = 0; k < 4 && !resumed; k++) begin
      @(negedge clk);
      if (d_gnt === 1'b1) resumed = 1'b1;
      step();
    end
    checks++;
    if (!resumed) begin
      errors++;
      $display("FAIL dump_resume: no data grant within 4 cycles after dump_req dropped");
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_dump();
    bit seen = 1'b0;
    dump_req = 1'b1;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (mem_createdump === 1'b1) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL middump_reach: createdump not seen within 6 cycles");
    end
    rst_n = 1'b0;
    dump_req = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (mem_createdump !== 1'b0 || dump_done !== 1'b0 || i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL middump_clear: cd=%b done=%b irv=%b drv=%b required 0 0 0 0",
               mem_createdump, dump_done, i_rvalid, d_rvalid);
    end
    i_req = 1'b1; i_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if (i_gnt !== 1'b1) begin
      errors++;
      $display("FAIL middump_run: i_gnt=%b required 1", i_gnt);
    end
    step();
    i_req = 1'b0;
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL middump_fetch: irv=%b irdata=%h required 1 beef", i_rvalid, i_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write_read();
    test_starve();
    test_random();
    test_dump();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
